// File: rtl/pressure_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pressure_sequencer_if
// Brief    : Operator/actuator bundle for the chamber pressure sequencer.
//            Suffixes are from the sequencer's point of view (_i in, _o out).
// Revision : 1.0 - initial release
// ============================================================================
interface pressure_sequencer_if #(
  parameter int LEVEL_W = 3
);
  logic               limit_i;
  logic               press_req_i;
  logic               vent_req_i;
  logic               door_open_i;
  logic               pump_on_o;
  logic               vent_on_o;
  logic               busy_o;
  logic               done_o;
  logic               fault_o;
  logic [LEVEL_W-1:0] level_o;

  // Operator/controller side: issues requests, observes status.
  modport master (
    output limit_i, press_req_i, vent_req_i, door_open_i,
    input  pump_on_o, vent_on_o, busy_o, done_o, fault_o, level_o
  );

  // Sequencer side.
  modport slave (
    input  limit_i, press_req_i, vent_req_i, door_open_i,
    output pump_on_o, vent_on_o, busy_o, done_o, fault_o, level_o
  );
endinterface
`default_nettype wire

// File: rtl/pressure_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pressure_sequencer
// Brief    : Steps chamber pressure up (pump) or down (vent) one level every
//            STEP_CYCLES clocks, with a door interlock that aborts to FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module pressure_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int NORM_LEVEL  = 3,
  parameter int MAX_LEVEL   = 6,
  parameter int LEVEL_W     = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pressure_sequencer_if.slave   bus_if
);

  localparam int c_CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PUMP  = 2'd1;
  localparam logic [1:0] c_VENT  = 2'd2;
  localparam logic [1:0] c_FAULT = 2'd3;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] c_NORM     = LEVEL_W'(NORM_LEVEL);
  localparam logic [LEVEL_W-1:0] c_MAX      = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] c_ZERO     = '0;
  localparam logic [LEVEL_W-1:0] c_ONE      = LEVEL_W'(1);

  logic [1:0]         state_q,  state_d;
  logic [LEVEL_W-1:0] level_q,  level_d;
  logic [c_CNT_W-1:0] cnt_q,    cnt_d;
  logic [LEVEL_W-1:0] target_q, target_d;
  logic               done_q,   done_d;

  logic [LEVEL_W-1:0] w_sel_target;
  logic [LEVEL_W-1:0] w_level_up;
  logic               w_cnt_last;

  assign w_sel_target = bus_if.limit_i ? c_MAX : c_NORM;
  assign w_level_up   = level_q + c_ONE;
  assign w_cnt_last   = (cnt_q == c_CNT_LAST);

  // Next-state logic: request acceptance, level stepping and door interlock.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state_q)
      c_IDLE: begin
        // Requests are only honoured with every door closed; vent wins ties.
        if (!bus_if.door_open_i) begin
          if (bus_if.vent_req_i) begin
            if (level_q == c_ZERO) begin
              done_d = 1'b1;
            end else begin
              state_d = c_VENT;
              cnt_d   = '0;
            end
          end else if (bus_if.press_req_i) begin
            // Already at or above the target: never vent down to reach it.
            if (level_q >= w_sel_target) begin
              done_d = 1'b1;
            end else begin
              state_d  = c_PUMP;
              cnt_d    = '0;
              target_d = w_sel_target;
            end
          end
        end
      end
      c_PUMP: begin
        if (bus_if.door_open_i) begin
          // Abort beats a same-cycle step: level stays where it is.
          state_d = c_FAULT;
          cnt_d   = '0;
        end else if (w_cnt_last) begin
          cnt_d = '0;
          if (level_q < c_MAX) begin
            level_d = w_level_up;
          end
          if ((w_level_up >= target_q) || (level_q >= c_MAX)) begin
            state_d = c_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      c_VENT: begin
        if (bus_if.door_open_i) begin
          state_d = c_FAULT;
          cnt_d   = '0;
        end else if (w_cnt_last) begin
          cnt_d = '0;
          if (level_q != c_ZERO) begin
            level_d = level_q - c_ONE;
          end
          if (level_q <= c_ONE) begin
            state_d = c_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      c_FAULT: begin
        // Only a vent with the door shut clears the fault; press is ignored.
        if (bus_if.vent_req_i && !bus_if.door_open_i) begin
          if (level_q == c_ZERO) begin
            state_d = c_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = c_VENT;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with immediate (asynchronous) reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign bus_if.pump_on_o = (state_q == c_PUMP);
  assign bus_if.vent_on_o = (state_q == c_VENT);
  assign bus_if.busy_o    = (state_q == c_PUMP) || (state_q == c_VENT);
  assign bus_if.fault_o   = (state_q == c_FAULT);
  assign bus_if.done_o    = done_q;
  assign bus_if.level_o   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_pressure_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pressure_sequencer
// Brief    : Directed self-checking bench for pressure_sequencer with an
//            operation-level reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pressure_sequencer;

  localparam int STEP = 4;
  localparam int NORM = 3;
  localparam int MAXL = 6;
  localparam int LW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;
  int npump = 0;
  int nvent = 0;
  int ndone = 0;

  pressure_sequencer_if #(.LEVEL_W(LW)) bus_if ();

  pressure_sequencer #(
    .STEP_CYCLES (STEP),
    .NORM_LEVEL  (NORM),
    .MAX_LEVEL   (MAXL),
    .LEVEL_W     (LW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: an operation is described by its start level, its end
  // level and the cycles elapsed; the visible level is derived arithmetically.
  int m_op   = 0;   // 0 idle, 1 pump, 2 vent, 3 fault
  int m_base = 0;
  int m_tgt  = 0;
  int m_el   = 0;
  int m_lvl  = 0;
  int m_done = 0;

  function automatic int cur_lvl();
    if (m_op == 1) return m_base + m_el / STEP;
    if (m_op == 2) return m_base - m_el / STEP;
    return m_lvl;
  endfunction

  function automatic int op_len();
    return ((m_tgt > m_base) ? (m_tgt - m_base) : (m_base - m_tgt)) * STEP;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_op <= 0; m_base <= 0; m_tgt <= 0; m_el <= 0; m_lvl <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (m_op == 0) begin
        if (!bus_if.door_open_i && bus_if.vent_req_i) begin
          if (m_lvl == 0) m_done <= 1;
          else begin m_op <= 2; m_base <= m_lvl; m_tgt <= 0; m_el <= 0; end
        end else if (!bus_if.door_open_i && bus_if.press_req_i) begin
          if (m_lvl >= (bus_if.limit_i ? MAXL : NORM)) m_done <= 1;
          else begin
            m_op <= 1; m_base <= m_lvl; m_el <= 0;
            m_tgt <= bus_if.limit_i ? MAXL : NORM;
          end
        end
      end else if (m_op == 1 || m_op == 2) begin
        if (bus_if.door_open_i) begin
          m_op <= 3; m_lvl <= cur_lvl();
        end else if (m_el + 1 == op_len()) begin
          m_op <= 0; m_lvl <= m_tgt; m_done <= 1;
        end else begin
          m_el <= m_el + 1;
        end
      end else begin
        if (bus_if.vent_req_i && !bus_if.door_open_i) begin
          if (m_lvl == 0) begin m_op <= 0; m_done <= 1; end
          else begin m_op <= 2; m_base <= m_lvl; m_tgt <= 0; m_el <= 0; end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, compare all outputs to the model,
  // and accumulate activity counts for the scenario-level checks.
  task automatic tick();
    @(negedge clk);
    chk("pump_on", int'(bus_if.pump_on_o), int'(m_op == 1));
    chk("vent_on", int'(bus_if.vent_on_o), int'(m_op == 2));
    chk("busy",    int'(bus_if.busy_o),    int'(m_op == 1 || m_op == 2));
    chk("fault",   int'(bus_if.fault_o),   int'(m_op == 3));
    chk("done",    int'(bus_if.done_o),    m_done);
    chk("level",   int'(bus_if.level_o),   cur_lvl());
    if (bus_if.pump_on_o) npump++;
    if (bus_if.vent_on_o) nvent++;
    if (bus_if.done_o)    ndone++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    npump = 0; nvent = 0; ndone = 0;
  endtask

  task automatic req(input logic p, input logic v);
    bus_if.press_req_i = p;
    bus_if.vent_req_i  = v;
    tick();
    bus_if.press_req_i = 1'b0;
    bus_if.vent_req_i  = 1'b0;
  endtask

  initial begin
    bus_if.limit_i     = 1'b0;
    bus_if.press_req_i = 1'b0;
    bus_if.vent_req_i  = 1'b0;
    bus_if.door_open_i = 1'b0;

    // Reset state
    idle(3);
    chk("rst_level", int'(bus_if.level_o), 0);
    chk("rst_busy",  int'(bus_if.busy_o),  0);
    rst = 1'b0;

    // 1: pump 0 -> 3 at normal range
    clr(); req(1'b1, 1'b0); idle(16);
    chk("s1_pump_cycles", npump, 12);
    chk("s1_done_count",  ndone, 1);
    chk("s1_level",       int'(bus_if.level_o), 3);

    // 2: extended range 3 -> 6, then normal-range press at 6 is a no-op
    bus_if.limit_i = 1'b1;
    clr(); req(1'b1, 1'b0); idle(16);
    chk("s2_pump_cycles", npump, 12);
    chk("s2_level",       int'(bus_if.level_o), 6);
    chk("s2_done_count",  ndone, 1);
    bus_if.limit_i = 1'b0;
    clr(); req(1'b1, 1'b0); idle(3);
    chk("s2_noop_pump",  npump, 0);
    chk("s2_noop_done",  ndone, 1);
    chk("s2_noop_level", int'(bus_if.level_o), 6);

    // 3: vent 6 -> 0, then vent at 0 just pulses done
    clr(); req(1'b0, 1'b1); idle(28);
    chk("s3_vent_cycles", nvent, 24);
    chk("s3_level",       int'(bus_if.level_o), 0);
    chk("s3_done_count",  ndone, 1);
    clr(); req(1'b0, 1'b1); idle(3);
    chk("s3_zero_done", ndone, 1);
    chk("s3_zero_vent", nvent, 0);

    // 4: door opens mid-pump, fault recovery
    clr(); req(1'b1, 1'b0); idle(5);
    bus_if.door_open_i = 1'b1;
    tick(); idle(2);
    chk("s4_fault", int'(bus_if.fault_o),   1);
    chk("s4_pump",  int'(bus_if.pump_on_o), 0);
    chk("s4_level", int'(bus_if.level_o),   1);
    chk("s4_done",  ndone, 0);
    req(1'b0, 1'b1); idle(3);
    chk("s4_door_ignored", int'(bus_if.fault_o), 1);
    bus_if.door_open_i = 1'b0;
    clr(); req(1'b0, 1'b1); idle(6);
    chk("s4_vent_cycles", nvent, 4);
    chk("s4_rec_level",   int'(bus_if.level_o), 0);
    chk("s4_rec_done",    ndone, 1);
    chk("s4_rec_fault",   int'(bus_if.fault_o), 0);

    // 5: vent wins simultaneous requests; requests while busy are dropped
    clr(); req(1'b1, 1'b1); idle(3);
    chk("s5_tie0_pump", npump, 0);
    chk("s5_tie0_done", ndone, 1);
    clr(); req(1'b1, 1'b0); idle(14);
    chk("s5_pre_level", int'(bus_if.level_o), 3);
    req(1'b0, 1'b1); idle(5);
    bus_if.door_open_i = 1'b1;
    tick();
    bus_if.door_open_i = 1'b0;
    idle(2);
    chk("s5_fault_level", int'(bus_if.level_o), 2);
    clr(); req(1'b1, 1'b1); idle(2); req(1'b1, 1'b0); idle(8);
    chk("s5_vent_cycles", nvent, 8);
    chk("s5_pump_cycles", npump, 0);
    chk("s5_level",       int'(bus_if.level_o), 0);
    chk("s5_done_count",  ndone, 1);

    // 6: asynchronous reset mid-pump at level 2
    clr(); req(1'b1, 1'b0); idle(9);
    chk("s6_pre_level", int'(bus_if.level_o), 2);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_level", int'(bus_if.level_o),   0);
    chk("s6_async_pump",  int'(bus_if.pump_on_o), 0);
    chk("s6_async_busy",  int'(bus_if.busy_o),    0);
    tick();
    rst = 1'b0;
    clr(); req(1'b1, 1'b0); idle(16);
    chk("s6_pump_cycles", npump, 12);
    chk("s6_level",       int'(bus_if.level_o), 3);
    chk("s6_done_count",  ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pressure_sequencer.md
Name: pressure_sequencer

Overview:
- Downstream consumer of the limit_pressure toggle flag in the chamber pressure path.
- Steps a chamber pressure level up (pump) or down (vent) on single-cycle operator requests, one level per STEP_CYCLES clocks.
- The limit flag selects the pressurization target: NORM_LEVEL when 0, MAX_LEVEL when 1.
- Aborts to a fault state when the door sensor opens mid-operation; drives the pump/vent actuators and status outputs.

Parameters:
STEP_CYCLES, 4, clocks per one-level pressure change (>=2)
NORM_LEVEL, 3, pressurization target when limit=0 (1..MAX_LEVEL)
MAX_LEVEL, 6, pressurization target when limit=1; absolute ceiling of level
LEVEL_W, 3, width of level register (2^LEVEL_W > MAX_LEVEL)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
limit  input  1  range select from limit_pressure (1 = extended range to MAX_LEVEL)
press_req  input  1  single-cycle pulse: pressurize to target
vent_req  input  1  single-cycle pulse: depressurize to level 0
door_open  input  1  level signal: any chamber door open
pump_on  output  1  pump actuator enable, registered
vent_on  output  1  vent valve enable, registered
busy  output  1  high in PUMP or VENT
done  output  1  one-cycle pulse on operation completion
fault  output  1  high in FAULT
level  output  LEVEL_W  current chamber pressure level, registered

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, level=0, step counter=0, latched target=0, all 1-bit outputs 0. Takes effect immediately, not at the next edge.
- States: IDLE, PUMP, VENT, FAULT. Outputs are Moore, decoded from registered state:
  - pump_on = PUMP
  - vent_on = VENT
  - busy = PUMP or VENT
  - fault = FAULT
- done is a registered one-cycle pulse.
- Target selection: on acceptance of press_req, target = limit ? MAX_LEVEL : NORM_LEVEL. Target is latched and held for the whole operation; limit changes during PUMP have no effect.
- IDLE:
  - vent_req and press_req in the same cycle: vent_req wins.
  - Either request while door_open=1: ignored, no fault, no done.
  - vent_req with level=0: done pulses next cycle, state stays IDLE.
  - vent_req with level>0: enter VENT.
  - press_req with level>=selected target: done pulses next cycle, state stays IDLE, level unchanged (no venting down to a lower target).
  - press_req with level<selected target: enter PUMP.
- PUMP/VENT:
  - Step counter clears on entry and counts 0..STEP_CYCLES-1.
  - At terminal count: level +1 (PUMP) or -1 (VENT), counter wraps to 0.
  - On the edge where level reaches the target (PUMP) or 0 (VENT): state becomes IDLE and done=1 for that one cycle.
  - An operation of N levels therefore holds pump_on/vent_on for exactly N*STEP_CYCLES cycles.
  - Requests arriving while busy are ignored (not queued).
- Door interlock: door_open=1 sampled in PUMP or VENT means next state is FAULT, the counter clears, level freezes at its current value, and no done pulse is issued. Abort takes priority over a same-cycle level step: the step does not happen.
- FAULT: actuators off. Exit only via vent_req with door_open=0, which enters VENT (or goes to IDLE with a done pulse if level=0). press_req is ignored in FAULT.
- Arithmetic: level never exceeds MAX_LEVEL and never wraps below 0. Out-of-range states recover to IDLE.

Test Plan:
(STEP_CYCLES=4, NORM_LEVEL=3, MAX_LEVEL=6)
1. After reset, limit=0, one press_req pulse -> pump_on high for exactly 12 cycles; level steps 1, 2, 3 at 4-cycle intervals; done pulses once as pump_on falls; level=3.
2. From level 3, set limit=1, press_req -> pump_on high for 12 cycles, level=6, done. Then limit=0, press_req -> immediate done, pump_on stays 0, level=6.
3. From level 6, vent_req -> vent_on high 24 cycles, level=0, done. A vent_req at level 0 -> done only.
4. press_req from level 0, door_open=1 at cycle 6 -> fault=1, pump_on=0, level=1 frozen, no done. Then vent_req with door_open=1 -> ignored. Then vent_req with door_open=0 -> VENT for 4 cycles, level=0, done.
5. press_req and vent_req in the same cycle at level 2 -> VENT wins, level reaches 0 after 8 cycles. Requests issued while busy -> no effect.
6. Assert reset asynchronously (between clock edges) mid-PUMP at level 2 -> all outputs 0 and level=0 immediately. After release, the first press_req behaves exactly as in scenario 1.
